bram_boot_sequencer: RTL
========================

Name: bram_boot_sequencer

Overview:
- Sequences program bring-up for single_cycle_BRAM_top-style cores: holds the core in reset, zero-fills the program BRAM, streams program words into it, then pulses start with the boot address.
- After start, measures run time in cycles until the core PC reaches a halt address.
- Owns the BRAM write port during bring-up; passes the core's memory port through otherwise.
- Sits between the host/debug loader stream and the core + memory.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDRESS_BITS, 32, core address and PC width.
- MEM_ADDRESS_BITS, 14, BRAM word-address width; depth = 2**MEM_ADDRESS_BITS.
- CYCLE_BITS, 32, run-cycle counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_req  in  1  one-cycle request to begin bring-up; sampled only in IDLE.
- load_base  in  MEM_ADDRESS_BITS  first word address to load.
- load_count  in  MEM_ADDRESS_BITS+1  number of words to load.
- boot_address  in  ADDRESS_BITS  value driven on program_address at start.
- halt_pc  in  ADDRESS_BITS  PC value that ends the run.
- in_valid  in  1  program word valid.
- in_data  in  DATA_WIDTH  program word.
- in_ready  out  1  sequencer accepts in_data (LOAD state only).
- pc  in  ADDRESS_BITS  core current PC.
- core_mem_write  in  1  core store request.
- core_mem_byte_en  in  DATA_WIDTH/8  core store byte enables.
- core_mem_address  in  MEM_ADDRESS_BITS  core word address.
- core_mem_data  in  DATA_WIDTH  core store data.
- mem_write  out  1  BRAM write enable.
- mem_byte_en  out  DATA_WIDTH/8  BRAM byte-lane enables.
- mem_address  out  MEM_ADDRESS_BITS  BRAM word address.
- mem_data  out  DATA_WIDTH  BRAM write data.
- core_reset  out  1  active-high reset to core.
- start  out  1  one-cycle start pulse.
- program_address  out  ADDRESS_BITS  registered boot address.
- busy  out  1  not IDLE and not DONE.
- done  out  1  halt reached; sticky until next load_req or reset.
- error  out  1  last request rejected; sticky until next accepted load_req.
- run_cycles  out  CYCLE_BITS  cycles from start pulse to halt detection.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; core_reset=1; start=0; program_address=0; done=0; error=0; run_cycles=0; in_ready=0.
  - Counters clear. Reset mid-LOAD aborts; BRAM contents are undefined.
- States: IDLE, CLEAR, LOAD, START, RUN, DONE.
- IDLE, on load_req:
  - If load_base+load_count > depth: set error=1, stay IDLE.
  - Otherwise: clear error and done, latch base/count/boot_address/halt_pc, go to CLEAR with addr=0.
- CLEAR:
  - mem_write=1, mem_byte_en all ones, mem_data=0, mem_address=addr; addr increments each cycle.
  - After writing address depth-1 (exactly depth cycles): addr=base, go to LOAD; if count=0, go to START.
- LOAD:
  - in_ready=1. A word is accepted on in_valid&in_ready and written the same cycle (all lanes, mem_address=addr).
  - addr increments, remaining count decrements.
  - Last word accepted -> START next cycle. in_valid low stalls indefinitely.
- START:
  - core_reset=0, start=1, program_address=latched boot_address for exactly one cycle; run counter=0.
  - -> RUN.
- RUN:
  - Counter increments every cycle.
  - When pc==halt_pc: run_cycles=counter, done=1, -> DONE. Halt on the first RUN cycle yields run_cycles=0.
  - Counter saturates at all ones.
- DONE:
  - Core remains out of reset. load_req restarts bring-up (core_reset=1 from the next cycle).
- Memory port mux:
  - In CLEAR/LOAD the sequencer drives mem_*; core_mem_* is ignored.
  - In all other states, mem_* = core_mem_* combinationally.
  - During LOAD, mem_write=0 when no word is accepted.
- core_reset=1 in IDLE, CLEAR, LOAD; 0 in START, RUN, DONE.
- load_req outside IDLE/DONE is ignored and does not set error.

Decomposition:
- Shared package boot_seq_pkg:
  - State encoding constants (3 bits).
  - Helper constant function for byte-lane count DATA_WIDTH/8.
- One natural sub-module: boot_mem_port_mux, the combinational selection of sequencer vs core BRAM port.
- FSM and counters stay in the top.

Test Plan (MEM_ADDRESS_BITS=4 unless noted):
- Reset then load_req, base=0, count=3, words 0x11,0x22,0x33 with in_valid always high -> 16 zero writes at addr 0..15; writes 0x11/0x22/0x33 at 0..2; start pulses once, program_address=boot_address; core_reset falls the same cycle.
- load_base=14, load_count=3 -> error=1, state stays IDLE, no mem_write, core_reset stays 1. A following valid request clears error.
- count=0 -> CLEAR completes, then START directly with no in_ready cycle.
- in_valid toggled 1,0,0,1,1 for 3 words -> in_ready held, writes only on valid cycles, addresses contiguous from base.
- RUN with pc driven to halt_pc=0xA8 on the 10th cycle after start -> done=1, run_cycles=9. core_mem_write passes to mem_write during RUN.
- Assert reset low mid-LOAD after 1 of 3 words -> core_reset=1, start=0, busy=0 immediately (async). A following load_req re-runs CLEAR from addr 0.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// ============================================================================
// Module      : boot_seq_pkg
// Description : Shared state encoding and helpers for the BRAM boot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_seq_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Number of byte lanes in a data word.
  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/boot_mem_port_mux.sv
// ============================================================================
// Module      : boot_mem_port_mux
// Description : Selects whether the sequencer or the core drives the BRAM
//               write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_mem_port_mux
  import boot_seq_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_ADDRESS_BITS = 14
) (
  input  logic                               sel,
  input  logic                               seq_write,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  seq_byte_en,
  input  logic [MEM_ADDRESS_BITS-1:0]        seq_address,
  input  logic [DATA_WIDTH-1:0]              seq_data,
  input  logic                               core_mem_write,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  core_mem_byte_en,
  input  logic [MEM_ADDRESS_BITS-1:0]        core_mem_address,
  input  logic [DATA_WIDTH-1:0]              core_mem_data,
  output logic                               mem_write,
  output logic [byte_lanes(DATA_WIDTH)-1:0]  mem_byte_en,
  output logic [MEM_ADDRESS_BITS-1:0]        mem_address,
  output logic [DATA_WIDTH-1:0]              mem_data
);

  // Sequencer owns the port while sel is high, otherwise the core passes through.
  always_comb begin
    if (sel) begin
      mem_write   = seq_write;
      mem_byte_en = seq_byte_en;
      mem_address = seq_address;
      mem_data    = seq_data;
    end else begin
      mem_write   = core_mem_write;
      mem_byte_en = core_mem_byte_en;
      mem_address = core_mem_address;
      mem_data    = core_mem_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_boot_sequencer.sv
// ============================================================================
// Module      : bram_boot_sequencer
// Description : Holds a core in reset, zero-fills and loads its program BRAM,
//               pulses start with the boot address, then times the run until
//               the PC reaches the halt address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 14,
  parameter int CYCLE_BITS       = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               load_req,
  input  logic [MEM_ADDRESS_BITS-1:0]        load_base,
  input  logic [MEM_ADDRESS_BITS:0]          load_count,
  input  logic [ADDRESS_BITS-1:0]            boot_address,
  input  logic [ADDRESS_BITS-1:0]            halt_pc,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               in_ready,
  input  logic [ADDRESS_BITS-1:0]            pc,
  input  logic                               core_mem_write,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  core_mem_byte_en,
  input  logic [MEM_ADDRESS_BITS-1:0]        core_mem_address,
  input  logic [DATA_WIDTH-1:0]              core_mem_data,
  output logic                               mem_write,
  output logic [byte_lanes(DATA_WIDTH)-1:0]  mem_byte_en,
  output logic [MEM_ADDRESS_BITS-1:0]        mem_address,
  output logic [DATA_WIDTH-1:0]              mem_data,
  output logic                               core_reset,
  output logic                               start,
  output logic [ADDRESS_BITS-1:0]            program_address,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [CYCLE_BITS-1:0]              run_cycles
);

  localparam int LANES = byte_lanes(DATA_WIDTH);
  // Memory depth expressed with two guard bits so base+count cannot overflow.
  localparam logic [MEM_ADDRESS_BITS+1:0] DEPTH_EXT = {2'b01, {MEM_ADDRESS_BITS{1'b0}}};

  state_t                      state;
  state_t                      next_state;
  logic [MEM_ADDRESS_BITS-1:0] addr;
  logic [MEM_ADDRESS_BITS-1:0] base_q;
  logic [MEM_ADDRESS_BITS:0]   count_q;
  logic [MEM_ADDRESS_BITS:0]   remaining;
  logic [ADDRESS_BITS-1:0]     halt_q;
  logic [CYCLE_BITS-1:0]       counter;

  logic                        seq_sel;
  logic                        seq_write;
  logic [DATA_WIDTH-1:0]       seq_data;

  logic [MEM_ADDRESS_BITS+1:0] range_end;
  logic                        out_of_range;
  logic                        req_window;
  logic                        accept;
  logic                        reject;
  logic                        clear_last;
  logic                        word_take;
  logic                        last_word;
  logic                        halt_hit;

  assign range_end    = {2'b00, load_base} + {1'b0, load_count};
  assign out_of_range = range_end > DEPTH_EXT;
  assign req_window   = (state == ST_IDLE) || (state == ST_DONE);
  assign accept       = load_req && req_window && !out_of_range;
  assign reject       = load_req && req_window && out_of_range;
  assign clear_last   = (addr == {MEM_ADDRESS_BITS{1'b1}});
  assign word_take    = (state == ST_LOAD) && in_valid;
  assign last_word    = word_take && (remaining == (MEM_ADDRESS_BITS+1)'(1));
  assign halt_hit     = (state == ST_RUN) && (pc == halt_q);
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    core_reset = 1'b1;
    seq_sel    = 1'b0;
    seq_write  = 1'b0;
    seq_data   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        seq_sel   = 1'b1;
        seq_write = 1'b1;
        if (clear_last) next_state = (count_q == '0) ? ST_START : ST_LOAD;
      end
      ST_LOAD: begin
        seq_sel   = 1'b1;
        in_ready  = 1'b1;
        seq_write = in_valid;
        seq_data  = in_data;
        if (last_word) next_state = ST_START;
      end
      ST_START: begin
        core_reset = 1'b0;
        start      = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        core_reset = 1'b0;
        if (halt_hit) next_state = ST_DONE;
      end
      ST_DONE: begin
        core_reset = 1'b0;
        if (accept) next_state = ST_CLEAR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request latching, fill/load address walk, run timer and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr            <= '0;
      base_q          <= '0;
      count_q         <= '0;
      remaining       <= '0;
      halt_q          <= '0;
      counter         <= '0;
      program_address <= '0;
      run_cycles      <= '0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      if (accept) begin
        error           <= 1'b0;
        done            <= 1'b0;
        base_q          <= load_base;
        count_q         <= load_count;
        program_address <= boot_address;
        halt_q          <= halt_pc;
        addr            <= '0;
      end else if (reject) begin
        error <= 1'b1;
      end
      case (state)
        ST_CLEAR: begin
          if (clear_last) begin
            addr      <= base_q;
            remaining <= count_q;
          end else begin
            addr <= addr + MEM_ADDRESS_BITS'(1);
          end
        end
        ST_LOAD: begin
          if (word_take) begin
            addr      <= addr + MEM_ADDRESS_BITS'(1);
            remaining <= remaining - (MEM_ADDRESS_BITS+1)'(1);
          end
        end
        ST_START: begin
          counter <= '0;
        end
        ST_RUN: begin
          if (halt_hit) begin
            run_cycles <= counter;
            done       <= 1'b1;
          end else if (counter != {CYCLE_BITS{1'b1}}) begin
            counter <= counter + CYCLE_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  boot_mem_port_mux #(
    .DATA_WIDTH       (DATA_WIDTH),
    .MEM_ADDRESS_BITS (MEM_ADDRESS_BITS)
  ) u_mux (
    .sel              (seq_sel),
    .seq_write        (seq_write),
    .seq_byte_en      ({LANES{1'b1}}),
    .seq_address      (addr),
    .seq_data         (seq_data),
    .core_mem_write   (core_mem_write),
    .core_mem_byte_en (core_mem_byte_en),
    .core_mem_address (core_mem_address),
    .core_mem_data    (core_mem_data),
    .mem_write        (mem_write),
    .mem_byte_en      (mem_byte_en),
    .mem_address      (mem_address),
    .mem_data         (mem_data)
  );

endmodule

`default_nettype wire
